// File: rtl/adder_disp_scan_pkg.sv
// Shared types and constants for the scanned adder display.
// Holds the FSM encoding, the digit/prescaler widths, the blank patterns and the digit mux helper.
package adder_disp_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    localparam int DIGIT_W = 2;
    typedef logic [DIGIT_W-1:0] digit_t;

    // Wide enough for DIV-1 at its largest legal value (2^20) and for BLANK-1.
    localparam int PRE_W = 20;
    typedef logic [PRE_W-1:0] pre_t;

    localparam logic [3:0] AN_BLANK  = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit 0 = sum, 1 = carry-in, 2 = B, 3 = A; all zero-extended to BCD.
    function automatic logic [3:0] digit_sel(input digit_t d, input logic [2:0] sum,
                                             input logic [1:0] ra, input logic [1:0] rb,
                                             input logic rcin);
        logic [3:0] v;
        case (d)
            2'd0:    v = {1'b0, sum};
            2'd1:    v = {3'b000, rcin};
            2'd2:    v = {2'b00, rb};
            default: v = {2'b00, ra};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/BCD_7.sv
// BCD to active-low 7-segment decoder, output order {g,f,e,d,c,b,a}.
// Purely combinational; codes 10..15 decode to all segments dark.
module BCD_7
    import adder_disp_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/adder2.sv
// Two-bit adder with carry-in and carry-out.
// Purely combinational; no handshake.
module adder2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {2'b00, cin};

endmodule

// File: rtl/adder_disp_scan.sv
// Scans sum / carry-in / B / A of a registered 2-bit addition over four 7-segment digits.
// Outputs are registered (1-cycle latency); no backpressure, load is accepted every cycle.
// Each digit is lit DIV cycles, then all digits are dark BLANK cycles before the next one.
module adder_disp_scan
    import adder_disp_scan_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int BLANK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [3:0] an,
    output logic [6:0] seg
);

    state_t     state, state_nxt;
    digit_t     digit, digit_nxt;
    pre_t       pre, pre_nxt;
    logic       enter_show;
    logic [1:0] ra, rb;
    logic       rcin;
    logic [3:0] val;
    logic [1:0] sum_s;
    logic       sum_c;
    logic [6:0] seg_dec;

    adder2 u_add (
        .a    (ra),
        .b    (rb),
        .cin  (rcin),
        .s    (sum_s),
        .cout (sum_c)
    );

    BCD_7 u_dec (
        .bcd (val),
        .seg (seg_dec)
    );

    always_comb begin
        state_nxt  = state;
        digit_nxt  = digit;
        pre_nxt    = pre;
        enter_show = 1'b0;
        if (!en) begin
            state_nxt = ST_IDLE;
            digit_nxt = '0;
            pre_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt  = ST_SHOW;
                    digit_nxt  = '0;
                    pre_nxt    = '0;
                    enter_show = 1'b1;
                end
                ST_SHOW: begin
                    if (pre == pre_t'(DIV - 1)) begin
                        state_nxt = ST_BLANK;
                        pre_nxt   = '0;
                    end else begin
                        pre_nxt = pre + 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (pre == pre_t'(BLANK - 1)) begin
                        state_nxt  = ST_SHOW;
                        pre_nxt    = '0;
                        digit_nxt  = digit + 1'b1;
                        enter_show = 1'b1;
                    end else begin
                        pre_nxt = pre + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    digit_nxt = '0;
                    pre_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            digit <= '0;
            pre   <= '0;
            ra    <= '0;
            rb    <= '0;
            rcin  <= 1'b0;
            val   <= '0;
            an    <= AN_BLANK;
            seg   <= SEG_BLANK;
        end else begin
            state <= state_nxt;
            digit <= digit_nxt;
            pre   <= pre_nxt;
            if (load) begin
                ra   <= a;
                rb   <= b;
                rcin <= cin;
            end
            // Latch uses the pre-load operands, so a load during SHOW shows up at the next entry.
            if (enter_show)
                val <= digit_sel(digit_nxt, {sum_c, sum_s}, ra, rb, rcin);
            if (state == ST_SHOW) begin
                an  <= ~(4'b0001 << digit);
                seg <= seg_dec;
            end else begin
                an  <= AN_BLANK;
                seg <= SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_adder_disp_scan.sv
// Bench for adder_disp_scan with DIV=4, BLANK=2: timeline model plus directed literal checks.
module tb_adder_disp_scan;

    localparam int TDIV   = 4;
    localparam int TBLANK = 2;
    localparam int PER    = TDIV + TBLANK;

    logic       clk = 1'b0;
    logic       rst, en, load, cin;
    logic [1:0] a, b;
    logic [3:0] an;
    logic [6:0] seg;

    int n_chk  = 0;
    int n_fail = 0;

    adder_disp_scan #(.DIV(TDIV), .BLANK(TBLANK)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .load (load),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .an   (an),
        .seg  (seg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Timeline model: m_t counts cycles since the scan started; digit and phase follow by division.
    bit         m_active = 1'b0;
    int         m_t = 0;
    int         m_ra = 0, m_rb = 0, m_rcin = 0, m_val = 0;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    bit         chk_on = 1'b0;

    function automatic int dig_val(input int d, input int ra, input int rb, input int rc);
        case (d)
            0: return ra + rb + rc;
            1: return rc;
            2: return rb;
            default: return ra;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_t = 0;
            m_ra = 0; m_rb = 0; m_rcin = 0; m_val = 0;
            m_an = 4'b1111;
            m_seg = 7'b1111111;
            chk_on = 1'b1;
        end else begin
            if (m_active && (m_t % PER) < TDIV) begin
                m_an  = ~(4'b0001 << ((m_t / PER) % 4));
                m_seg = seg_of(m_val);
            end else begin
                m_an  = 4'b1111;
                m_seg = 7'b1111111;
            end
            if (!en) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_t = 0;
                m_val = dig_val(0, m_ra, m_rb, m_rcin);
            end else begin
                m_t = m_t + 1;
                if (m_t % PER == 0)
                    m_val = dig_val((m_t / PER) % 4, m_ra, m_rb, m_rcin);
            end
            if (load) begin
                m_ra = int'(a); m_rb = int'(b); m_rcin = int'(cin);
            end
        end
    end

    logic [3:0] last_lit = 4'b1111;
    int         dark_run = 100;

    always @(negedge clk) begin
        if (chk_on) begin
            n_chk++;
            if (an !== m_an || seg !== m_seg) begin
                n_fail++;
                $display("FAIL model t=%0t an=%b seg=%b expected an=%b seg=%b",
                         $time, an, seg, m_an, m_seg);
            end
            n_chk++;
            if ($countones(~an) > 1) begin
                n_fail++;
                $display("FAIL onehot t=%0t an=%b expected at most one low bit", $time, an);
            end
            if (an == 4'b1111) begin
                n_chk++;
                if (seg !== 7'b1111111) begin
                    n_fail++;
                    $display("FAIL dark_seg t=%0t seg=%b expected 1111111", $time, seg);
                end
                dark_run++;
            end else begin
                if (an != last_lit && last_lit != 4'b1111) begin
                    n_chk++;
                    if (dark_run < TBLANK) begin
                        n_fail++;
                        $display("FAIL gap t=%0t an=%b dark=%0d expected >=%0d",
                                 $time, an, dark_run, TBLANK);
                    end
                end
                last_lit = an;
                dark_run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string nm, input logic [3:0] ea, input logic [6:0] es);
        n_chk++;
        if (an !== ea || seg !== es) begin
            n_fail++;
            $display("FAIL %s an=%b seg=%b expected an=%b seg=%b", nm, an, seg, ea, es);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; a = 2'd0; b = 2'd0; cin = 1'b0;
        tick();
        tick();
        lit("reset", 4'b1111, 7'b1111111);
        rst = 1'b0;
        load = 1'b1; a = 2'd2; b = 2'd3; cin = 1'b1;
        tick();
        load = 1'b0;
        lit("idle_dark", 4'b1111, 7'b1111111);
        en = 1'b1;
        tick();
        lit("enter_latency", 4'b1111, 7'b1111111);
        for (int k = 1; k <= 60; k++) begin
            load = 1'b0;
            if (k == 13) begin
                load = 1'b1; a = 2'd3; b = 2'd3; cin = 1'b1;
            end
            if (k == 44) en = 1'b0;
            if (k == 47) en = 1'b1;
            rst = (k == 52);
            tick();
            case (k)
                1:  lit("d0_sum6_first", 4'b1110, 7'b0000010);
                4:  lit("d0_sum6_last", 4'b1110, 7'b0000010);
                5:  lit("blank_a", 4'b1111, 7'b1111111);
                6:  lit("blank_b", 4'b1111, 7'b1111111);
                7:  lit("d1_cin1", 4'b1101, 7'b1111001);
                14: lit("d2_hold_b3", 4'b1011, 7'b0110000);
                19: lit("d3_new_a3", 4'b0111, 7'b0110000);
                25: lit("d0_sum7", 4'b1110, 7'b1111000);
                31: lit("d1_cin1_pass2", 4'b1101, 7'b1111001);
                44: lit("d3_before_off", 4'b0111, 7'b0110000);
                45: lit("en_off_dark", 4'b1111, 7'b1111111);
                47: lit("reenable_latency", 4'b1111, 7'b1111111);
                48: lit("reenable_d0", 4'b1110, 7'b1111000);
                52: lit("rst_in_blank", 4'b1111, 7'b1111111);
                53: lit("after_rst_idle", 4'b1111, 7'b1111111);
                54: lit("after_rst_d0_zero", 4'b1110, 7'b1000000);
                default: ;
            endcase
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_disp_scan.md
ADDER_DISP_SCAN -- requirements
Module: adder_disp_scan

Interface
REQ-001 Parameter DIV, default 100000, number of clk cycles each digit is lit (SHOW phase); legal range 2..2^20.
REQ-002 Parameter BLANK, default 4, number of clk cycles all digits are dark between digits (BLANK phase); legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 en  in  1  display enable; 0 forces all digits dark.
REQ-006 load  in  1  single-cycle strobe; captures a, b, cin into operand registers.
REQ-007 a  in  2  operand A (0..3).
REQ-008 b  in  2  operand B (0..3).
REQ-009 cin  in  1  carry-in.
REQ-010 an  out  4  digit anodes, active-low, one-hot-low when lit.
REQ-011 seg  out  7  segment cathodes {g,f,e,d,c,b,a}, active-low.

Function
REQ-012 The block SHALL time-multiplex one BCD-to-7-segment decoder across four digits: digit 0 = sum, digit 1 = carry-in, digit 2 = B, digit 3 = A.
REQ-013 Sum SHALL be the 3-bit value {cout,s} = ra + rb + rcin of the registered operands, range 0..7, zero-extended to 4-bit BCD; other digits zero-extended likewise.
REQ-014 On load=1, ra/rb/rcin SHALL take a/b/cin at that edge; load is accepted in every state, including IDLE.
REQ-015 FSM states: IDLE, SHOW, BLANK.
REQ-016 IDLE -> SHOW when en=1, with digit index 0 and prescaler 0.
REQ-017 SHOW lasts exactly DIV cycles, then -> BLANK with prescaler cleared.
REQ-018 BLANK lasts exactly BLANK cycles, then -> SHOW with digit index incremented modulo 4 (3 wraps to 0).
REQ-019 Any state -> IDLE on the cycle after en=0; a later re-enable SHALL restart at digit 0.
REQ-020 The 4-bit digit value SHALL be latched on entry to SHOW and held for the whole SHOW phase; a load during SHOW SHALL first appear at the next SHOW entry.
REQ-021 an and seg SHALL be registered; they reflect the state/digit of the previous cycle (1-cycle latency).
REQ-022 While lit: an = ~(4'b0001 << digit) and seg = decode(latched value); in IDLE and BLANK: an = 4'b1111, seg = 7'b1111111.
REQ-023 No two anodes SHALL ever be low in the same cycle; an SHALL never go from one lit digit to another without at least BLANK dark cycles between them.
REQ-024 Simultaneous load and en falling edge: both take effect; operands update and the FSM enters IDLE.

Reset
REQ-025 rst=1 SHALL, at the next edge, set state=IDLE, digit=0, prescaler=0, ra=rb=0, rcin=0, latched value=0, an=4'b1111, seg=7'b1111111.
REQ-026 rst SHALL take priority over en and load; rst asserted mid-SHOW or mid-BLANK SHALL blank outputs on the following cycle.

Structure
REQ-027 FSM state encodings, digit-index width and the blank patterns (4'b1111, 7'b1111111) SHALL live in the shared display package.
REQ-028 Addition SHALL reuse the existing adder2 instance, and decoding SHALL reuse the existing BCD_7 decoder as the single sub-module; the block SHALL contain no second decoder.

Verification (DIV=4, BLANK=2)
REQ-029 Reset, en=1, load a=2,b=3,cin=1: digit 0 shows 6, then digits 1/2/3 show 1/3/2, then back to 6; each is lit 4 cycles with 2 dark cycles between.
REQ-030 load a=3,b=3,cin=1 mid-SHOW of digit 2: the current digit keeps its old value; the next pass shows sum 7 on an=1110.
REQ-031 en=0 mid-SHOW of digit 3 -> an=1111 within 2 cycles; en=1 again -> digit 0 lit first after the 1-cycle output latency.
REQ-032 rst pulsed during BLANK -> an=1111, seg=1111111, operands 0; with en=1, digit 0 then shows 0.
REQ-033 Every cycle of every test: an has at most one zero bit; an=1111 implies seg=1111111.
